// File: rtl/gpio_irq_slave_if.sv
`default_nettype none
// ============================================================================
// Module      : gpio_irq_slave_if
// Description : 64-bit data-bus interface to the GPIO peripheral with a
//               one-cycle read latency.
// Revision    : 1.0 - initial release
// ============================================================================
interface gpio_irq_slave_if;
    logic        cs;
    logic        we;
    logic        re;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] rdata;
    logic        rvalid;

    modport master (
        output cs, we, re, addr, wdata,
        input  rdata, rvalid
    );

    modport slave (
        input  cs, we, re, addr, wdata,
        output rdata, rvalid
    );
endinterface
`default_nettype wire

// File: rtl/gpio_irq_slave.sv
`default_nettype none
// ============================================================================
// Module      : gpio_irq_slave
// Description : Memory-mapped GPIO with synchronised inputs, per-pin edge
//               detection and a maskable level interrupt. Optional per-pin
//               debounce is enabled by defining GPIO_DEBOUNCE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module gpio_irq_slave #(
    parameter int          NR_GPIOS   = 8,
    parameter logic [63:0] BASE_ADDR  = 64'h0000_0000_0001_0000,
    parameter logic [63:0] ID_VALUE   = 64'h0000_0000_0000_0001,
    parameter int          DEB_CYCLES = 16
) (
    input  wire logic                clk,
    input  wire logic                rst,
    gpio_irq_slave_if.slave          bus,
    input  wire logic [NR_GPIOS-1:0] gpio_i,
    output logic      [NR_GPIOS-1:0] gpio_o,
    output logic      [NR_GPIOS-1:0] gpio_oe,
    output logic                     irq
);

    localparam logic [63:0] c_WIN_BYTES = 64'h40;
    localparam logic [2:0]  c_REG_ID    = 3'd0;
    localparam logic [2:0]  c_REG_DIR   = 3'd1;
    localparam logic [2:0]  c_REG_DATA  = 3'd2;
    localparam logic [2:0]  c_REG_EDGE  = 3'd3;
    localparam logic [2:0]  c_REG_RIS   = 3'd4;
    localparam logic [2:0]  c_REG_IMSC  = 3'd5;
    localparam logic [2:0]  c_REG_MIS   = 3'd6;

    logic [NR_GPIOS-1:0] r_dir_q,   w_dir_d;
    logic [NR_GPIOS-1:0] r_out_q,   w_out_d;
    logic [NR_GPIOS-1:0] r_edge_q,  w_edge_d;
    logic [NR_GPIOS-1:0] r_ris_q,   w_ris_d;
    logic [NR_GPIOS-1:0] r_imsc_q,  w_imsc_d;
    logic [NR_GPIOS-1:0] r_sync1_q, r_sync2_q, r_prev_q;
    logic                r_irq_q,   w_irq_d;
    logic                r_rvalid_q, w_rvalid_d;
    logic [63:0]         r_rdata_q, w_rdata_d;

    logic [63:0]         w_offset;
    logic [2:0]          w_idx;
    logic                w_hit, w_wr, w_rd;
    logic [NR_GPIOS-1:0] w_wpins, w_level, w_evt, w_clr;
    logic [63:0]         w_rsel;
    logic                w_unused;

    // Addresses below BASE_ADDR wrap to huge offsets and fall outside the window.
    assign w_offset = bus.addr - BASE_ADDR;
    assign w_hit    = bus.cs && (w_offset < c_WIN_BYTES);
    assign w_idx    = w_offset[5:3];
    assign w_wr     = w_hit && bus.we;
    assign w_rd     = bus.cs && bus.re;
    assign w_wpins  = bus.wdata[NR_GPIOS-1:0];
    assign w_unused = &{1'b0, bus.wdata, w_offset};

`ifdef GPIO_DEBOUNCE_EN
    localparam int c_CNT_W = $clog2(DEB_CYCLES + 1);

    logic [c_CNT_W-1:0]  r_cnt_q [NR_GPIOS];
    logic [c_CNT_W-1:0]  w_cnt_d [NR_GPIOS];
    logic [NR_GPIOS-1:0] r_stable_q, w_stable_d;

    // Stable value flips on the DEB_CYCLES-th consecutive differing cycle.
    always_comb begin
        w_stable_d = r_stable_q;
        for (int i = 0; i < NR_GPIOS; i++) begin
            w_cnt_d[i] = '0;
            if (r_sync2_q[i] != r_stable_q[i]) begin
                if (r_cnt_q[i] == c_CNT_W'(DEB_CYCLES - 1))
                    w_stable_d[i] = r_sync2_q[i];
                else
                    w_cnt_d[i] = r_cnt_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stable_q <= '0;
            for (int i = 0; i < NR_GPIOS; i++) r_cnt_q[i] <= '0;
        end else begin
            r_stable_q <= w_stable_d;
            for (int i = 0; i < NR_GPIOS; i++) r_cnt_q[i] <= w_cnt_d[i];
        end
    end

    assign w_level = r_stable_q;
`else
    assign w_level = r_sync2_q;
`endif

    assign w_evt = (w_level & ~r_prev_q & ~r_edge_q) | (~w_level & r_prev_q & r_edge_q);

    always_comb begin
        w_dir_d  = r_dir_q;
        w_out_d  = r_out_q;
        w_edge_d = r_edge_q;
        w_imsc_d = r_imsc_q;
        w_clr    = '0;
        if (w_wr) begin
            case (w_idx)
                c_REG_DIR:  w_dir_d  = w_wpins;
                c_REG_DATA: w_out_d  = w_wpins;
                c_REG_EDGE: w_edge_d = w_wpins;
                c_REG_RIS:  w_clr    = w_wpins;
                c_REG_IMSC: w_imsc_d = w_wpins;
                default:    ;
            endcase
        end
        // A new edge in the same cycle as its W1C keeps the bit set.
        w_ris_d = (r_ris_q & ~w_clr) | w_evt;
        w_irq_d = |(r_ris_q & r_imsc_q);
    end

    always_comb begin
        w_rsel = '0;
        case (w_idx)
            c_REG_ID:   w_rsel                 = ID_VALUE;
            c_REG_DIR:  w_rsel[NR_GPIOS-1:0]   = r_dir_q;
            c_REG_DATA: w_rsel[NR_GPIOS-1:0]   = (r_dir_q & r_out_q) | (~r_dir_q & w_level);
            c_REG_EDGE: w_rsel[NR_GPIOS-1:0]   = r_edge_q;
            c_REG_RIS:  w_rsel[NR_GPIOS-1:0]   = r_ris_q;
            c_REG_IMSC: w_rsel[NR_GPIOS-1:0]   = r_imsc_q;
            c_REG_MIS:  w_rsel[NR_GPIOS-1:0]   = r_ris_q & r_imsc_q;
            default:    w_rsel                 = '0;
        endcase
        w_rvalid_d = 1'b0;
        w_rdata_d  = r_rdata_q;
        if (w_rd) begin
            w_rvalid_d = 1'b1;
            w_rdata_d  = w_hit ? w_rsel : 64'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dir_q    <= '0;
            r_out_q    <= '0;
            r_edge_q   <= '0;
            r_ris_q    <= '0;
            r_imsc_q   <= '0;
            r_sync1_q  <= '0;
            r_sync2_q  <= '0;
            r_prev_q   <= '0;
            r_irq_q    <= 1'b0;
            r_rvalid_q <= 1'b0;
            r_rdata_q  <= '0;
        end else begin
            r_dir_q    <= w_dir_d;
            r_out_q    <= w_out_d;
            r_edge_q   <= w_edge_d;
            r_ris_q    <= w_ris_d;
            r_imsc_q   <= w_imsc_d;
            r_sync1_q  <= gpio_i;
            r_sync2_q  <= r_sync1_q;
            r_prev_q   <= w_level;
            r_irq_q    <= w_irq_d;
            r_rvalid_q <= w_rvalid_d;
            r_rdata_q  <= w_rdata_d;
        end
    end

    assign bus.rdata  = r_rdata_q;
    assign bus.rvalid = r_rvalid_q;
    assign gpio_o     = r_out_q;
    assign gpio_oe    = r_dir_q;
    assign irq        = r_irq_q;

endmodule
`default_nettype wire

// File: tb/tb_gpio_irq_slave.sv
`default_nettype none
// ============================================================================
// Module      : tb_gpio_irq_slave
// Description : Directed self-checking bench for gpio_irq_slave.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gpio_irq_slave;

    localparam logic [63:0] c_BASE = 64'h0000_0000_0001_0000;
    localparam logic [63:0] c_ID   = 64'h0;
    localparam logic [63:0] c_DIR  = 64'h08;
    localparam logic [63:0] c_DATA = 64'h10;
    localparam logic [63:0] c_EDGE = 64'h18;
    localparam logic [63:0] c_RIS  = 64'h20;
    localparam logic [63:0] c_IMSC = 64'h28;
    localparam logic [63:0] c_MIS  = 64'h30;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] gpio_i = 8'h00;
    logic [7:0] gpio_o;
    logic [7:0] gpio_oe;
    logic       irq;
    logic [63:0] rd;
    int n_checks = 0;
    int n_errors = 0;

    gpio_irq_slave_if bus ();

    gpio_irq_slave #(
        .NR_GPIOS   (8),
        .BASE_ADDR  (c_BASE),
        .ID_VALUE   (64'h1),
        .DEB_CYCLES (16)
    ) u_dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .gpio_i  (gpio_i),
        .gpio_o  (gpio_o),
        .gpio_oe (gpio_oe),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout reached before summary");
        $fatal(1, "timeout");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic bus_write(input logic [63:0] off, input logic [63:0] data);
        bus.cs = 1'b1; bus.we = 1'b1; bus.re = 1'b0;
        bus.addr = c_BASE + off; bus.wdata = data;
        tick();
        bus.cs = 1'b0; bus.we = 1'b0;
    endtask

    // Issues one read and returns the data captured in the following cycle.
    task automatic bus_read(input logic [63:0] off, output logic [63:0] data);
        bus.cs = 1'b1; bus.we = 1'b0; bus.re = 1'b1;
        bus.addr = c_BASE + off;
        tick();
        check_eq("rvalid_pulse", {63'd0, bus.rvalid}, 64'd1);
        data = bus.rdata;
        bus.cs = 1'b0; bus.re = 1'b0;
    endtask

    initial begin
        bus.cs = 1'b0; bus.we = 1'b0; bus.re = 1'b0;
        bus.addr = '0; bus.wdata = '0;
        ticks(3);
        rst = 1'b0;
        tick();
        check_eq("reset_rvalid", {63'd0, bus.rvalid}, 64'd0);
        check_eq("reset_rdata", bus.rdata, 64'd0);
        check_eq("reset_irq", {63'd0, irq}, 64'd0);
        check_eq("reset_gpio_o", {56'd0, gpio_o}, 64'd0);
        check_eq("reset_gpio_oe", {56'd0, gpio_oe}, 64'd0);

        bus_read(c_ID, rd);   check_eq("id", rd, 64'h1);
        bus_read(c_DIR, rd);  check_eq("dir_reset", rd, 64'h0);
        bus_read(c_RIS, rd);  check_eq("ris_reset", rd, 64'h0);
        tick();
        check_eq("rvalid_drop", {63'd0, bus.rvalid}, 64'd0);
        check_eq("rdata_hold", bus.rdata, 64'd0);

        bus_write(c_DIR, 64'h0F);
        bus_write(c_DATA, 64'hA5);
        check_eq("gpio_oe", {56'd0, gpio_oe}, 64'h0F);
        check_eq("gpio_o", {56'd0, gpio_o}, 64'hA5);

`ifdef GPIO_DEBOUNCE_EN
        gpio_i = 8'h04;
        ticks(10);
        gpio_i = 8'h00;
        ticks(40);
        bus_read(c_RIS, rd);  check_eq("deb_glitch", rd, 64'h0);
        gpio_i = 8'h04;
        ticks(17);
        bus_read(c_RIS, rd);  check_eq("deb_not_yet", rd, 64'h0);
        ticks(3);
        gpio_i = 8'h00;
        ticks(5);
        bus_read(c_RIS, rd);  check_eq("deb_pulse", rd, 64'h04);
        bus_write(c_RIS, 64'hFF);
`else
        gpio_i = 8'h30;
        ticks(2);
        bus_read(c_DATA, rd); check_eq("data_mix", rd, 64'h35);
        ticks(2);
        bus_read(c_RIS, rd);  check_eq("ris_dir_indep", rd, 64'h30);
        bus_write(c_RIS, 64'hFF);
        bus_read(c_RIS, rd);  check_eq("ris_w1c_all", rd, 64'h0);

        // Rising edge on pin 0 with the interrupt enabled.
        bus_write(c_IMSC, 64'h01);
        gpio_i = 8'h31;
        ticks(2);
        bus_read(c_RIS, rd);  check_eq("ris_before_3rd_edge", rd, 64'h0);
        check_eq("irq_before", {63'd0, irq}, 64'd0);
        bus_read(c_RIS, rd);  check_eq("ris_after_3rd_edge", rd, 64'h01);
        check_eq("irq_set", {63'd0, irq}, 64'd1);
        bus_write(c_RIS, 64'h01);
        check_eq("irq_lag", {63'd0, irq}, 64'd1);
        tick();
        check_eq("irq_clear", {63'd0, irq}, 64'd0);
        bus_read(c_RIS, rd);  check_eq("ris_cleared", rd, 64'h0);

        // Falling-edge configuration on pin 1, interrupt masked.
        bus_write(c_EDGE, 64'h02);
        bus_write(c_IMSC, 64'h00);
        gpio_i = 8'h33;
        ticks(4);
        bus_read(c_RIS, rd);  check_eq("fall_cfg_rise", rd, 64'h0);
        gpio_i = 8'h31;
        ticks(4);
        bus_read(c_RIS, rd);  check_eq("fall_cfg_fall", rd, 64'h02);
        check_eq("irq_masked", {63'd0, irq}, 64'd0);
        bus_read(c_MIS, rd);  check_eq("mis_masked", rd, 64'h0);

        // Edge landing on the same edge as its W1C.
        bus_write(c_RIS, 64'h02);
        gpio_i = 8'h30;
        ticks(4);
        gpio_i = 8'h31;
        ticks(2);
        bus_write(c_RIS, 64'h01);
        bus_read(c_RIS, rd);  check_eq("set_beats_clear", rd, 64'h01);
`endif

        bus_read(64'h40, rd);   check_eq("oor_read_hi", rd, 64'h0);
        bus_read(-64'sd8, rd);  check_eq("oor_read_lo", rd, 64'h0);
        bus_read(64'h38, rd);   check_eq("reserved_read", rd, 64'h0);
        bus_write(64'h48, 64'hFF);
        bus_read(c_DIR, rd);    check_eq("oor_write_ignored", rd, 64'h0F);

        bus_write(c_DIR, 64'hFFFF_FFFF_FFFF_FFFF);
        bus_read(c_DIR, rd);    check_eq("dir_width", rd, 64'hFF);

        bus.cs = 1'b1; bus.we = 1'b1; bus.re = 1'b1;
        bus.addr = c_BASE + c_DIR; bus.wdata = 64'h55;
        tick();
        check_eq("rw_same_old", bus.rdata, 64'hFF);
        bus.cs = 1'b0; bus.we = 1'b0; bus.re = 1'b0;
        bus_read(c_DIR, rd);    check_eq("rw_same_new", rd, 64'h55);
        check_eq("gpio_oe_new", {56'd0, gpio_oe}, 64'h55);

        // Interrupt active, then reset lands on the same edge as a read.
        bus_write(c_RIS, 64'hFF);
        bus_write(c_EDGE, 64'h00);
        gpio_i = 8'h00;
        ticks(40);
        gpio_i = 8'h80;
        bus_write(c_IMSC, 64'h80);
        ticks(40);
        check_eq("irq_pre_reset", {63'd0, irq}, 64'd1);
        bus.cs = 1'b1; bus.re = 1'b1; bus.addr = c_BASE + c_ID;
        rst = 1'b1;
        tick();
        bus.cs = 1'b0; bus.re = 1'b0;
        check_eq("rst_rvalid_drop", {63'd0, bus.rvalid}, 64'd0);
        check_eq("rst_irq", {63'd0, irq}, 64'd0);
        check_eq("rst_gpio_oe", {56'd0, gpio_oe}, 64'd0);
        check_eq("rst_gpio_o", {56'd0, gpio_o}, 64'd0);
        gpio_i = 8'h00;
        rst = 1'b0;
        bus_read(c_IMSC, rd);   check_eq("rst_imsc", rd, 64'h0);
        bus_read(c_RIS, rd);    check_eq("rst_ris", rd, 64'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
